// File: rtl/systolic_writeback_if.sv
// Row-in / byte-write-out bus for the systolic result drain stage.
// master = writeback stage, slave = upstream row source plus memory arbiter.
interface systolic_writeback_if #(
  parameter int DATA_W = 8,
  parameter int COLS   = 4,
  parameter int ADDR_W = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [COLS*DATA_W-1:0] row_data;
  logic                   mem_req;
  logic                   mem_gnt;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;

  modport master (
    input  in_valid,
    input  row_data,
    input  mem_gnt,
    output in_ready,
    output mem_req,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output in_valid,
    output row_data,
    output mem_gnt,
    input  in_ready,
    input  mem_req,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/systolic_writeback.sv
// Drains finished result rows into Feature Memory one byte per grant.
// Optional WB_CHECKSUM_EN adds a running sum of granted write data.
module systolic_writeback #(
  parameter int DATA_W    = 8,
  parameter int COLS      = 4,
  parameter int ROWS      = 4,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  systolic_writeback_if.master bus,
  output logic busy,
  output logic done
`ifdef WB_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_t;

  state_t                 state;
  logic [RW-1:0]          row_idx;
  logic [CW-1:0]          col_idx;
  logic [CW-1:0]          col_nxt;
  logic [COLS*DATA_W-1:0] row_q;
  logic                   accept;

  assign col_nxt = col_idx + CW'(1);
  assign accept  = (state == IDLE) && bus.in_ready && bus.in_valid;

  // Address math done in int, then truncated so it wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [RW-1:0] r,
    input logic [CW-1:0] c
  );
    int a;
    a = BASE_ADDR + COLS * int'(r) + int'(c);
    return a[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      row_idx       <= '0;
      col_idx       <= '0;
      row_q         <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (start) begin
      state        <= IDLE;
      row_idx      <= '0;
      col_idx      <= '0;
      bus.in_ready <= 1'b1;
      bus.mem_req  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state         <= WRITE;
            row_q         <= bus.row_data;
            col_idx       <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_req   <= 1'b1;
            busy          <= 1'b1;
            bus.mem_addr  <= addr_of(row_idx, '0);
            bus.mem_wdata <= bus.row_data[DATA_W-1:0];
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.mem_gnt) begin
            if (col_idx == COL_LAST) begin
              col_idx     <= '0;
              bus.mem_req <= 1'b0;
              busy        <= 1'b0;
              if (row_idx == ROW_LAST) begin
                row_idx <= '0;
                state   <= DONE;
                done    <= 1'b1;
              end else begin
                row_idx      <= row_idx + RW'(1);
                state        <= IDLE;
                bus.in_ready <= 1'b1;
              end
            end else begin
              col_idx       <= col_nxt;
              bus.mem_addr  <= addr_of(row_idx, col_nxt);
              bus.mem_wdata <= row_q[int'(col_nxt)*DATA_W +: DATA_W];
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          done         <= 1'b0;
          bus.in_ready <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.mem_req  <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

`ifdef WB_CHECKSUM_EN
  logic grant;
  assign grant = bus.mem_req && bus.mem_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (grant) begin
      checksum <= checksum + {{ADDR_W{1'b0}}, bus.mem_wdata};
    end
  end
`endif

endmodule
